// File: rtl/bfm_ahbslave_waitmem_pkg.sv
// Shared AHB-Lite slave BFM definitions: transfer codes, FSM states and
// the byte-lane mask helper.
package ahb_bfm_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;

  // Lanes covered by a (1 << hsize)-byte access starting at addr_lsbs,
  // clipped to the nbytes lanes of the bus.
  function automatic logic [7:0] bytemask(input logic [2:0] addr_lsbs,
                                          input logic [2:0] hsize,
                                          input int         nbytes);
    logic [15:0] m;
    logic [15:0] lim;
    m   = ((16'd1 << (16'd1 << hsize)) - 16'd1) << addr_lsbs;
    lim = (16'd1 << nbytes) - 16'd1;
    return m[7:0] & lim[7:0];
  endfunction

endpackage

// File: rtl/bfm_ahbslave_waitmem_if.sv
// AHB-Lite slave-side bus bundle; master drives the address/data phase,
// slave returns read data, ready and response.
interface bfm_ahbslave_waitmem_if #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 32
);
  logic              HSEL;
  logic [AWIDTH-1:0] HADDR;
  logic              HWRITE;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [3:0]        HPROT;
  logic              HMASTLOCK;
  logic              HREADYIN;
  logic [DWIDTH-1:0] HWDATA;
  logic [DWIDTH-1:0] HRDATA;
  logic              HREADYOUT;
  logic              HRESP;

  modport master (
    output HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK,
           HREADYIN, HWDATA,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK,
           HREADYIN, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/bfm_ahbslave_waitmem_mem_array.sv
// DEPTH x DWIDTH RAM with per-byte write enables and one registered read port.
// The array itself is never reset; only the read register is.
module ahb_slave_mem_array #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 256,
  localparam int NB    = DWIDTH / 8,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [IW-1:0]     waddr_i,
  input  logic [NB-1:0]     be_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IW-1:0]     raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DWIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Write-first per lane, so a read issued on the committing edge sees new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      for (int b = 0; b < NB; b++) begin
        rdata_q[8*b +: 8] <= (we_i && be_i[b] && (waddr_i == raddr_i)) ?
                             wdata_i[8*b +: 8] : mem[raddr_i][8*b +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bfm_ahbslave_waitmem.sv
// AHB-Lite slave memory with programmable wait states, byte-lane writes and
// two-cycle ERROR responses for out-of-range, oversized or misaligned accesses.
module bfm_ahbslave_waitmem
  import ahb_bfm_pkg::*;
#(
  parameter int AWIDTH      = 12,
  parameter int DWIDTH      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  bfm_ahbslave_waitmem_if.slave bus
);

  localparam int          NB    = DWIDTH / 8;
  localparam int          LSB   = $clog2(NB);
  localparam int          IW    = $clog2(DEPTH);
  localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'(NB);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            write_q, write_d;
  logic            hready_q, hresp_q;
  logic [IW-1:0]   widx_q, widx_d;
  logic [NB-1:0]   be_q, be_d;

  logic            accept;
  logic            illegal;
  logic [7:0]      amask;
  logic [7:0]      bm;
  logic            rd_en;
  logic [IW-1:0]   rd_idx;
  logic            mem_we;
  logic [DWIDTH-1:0] rdata;
  logic            unused_ok;

  assign unused_ok = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HTRANS[0]};

  assign accept = (state_q inside {IDLE, DATA, ERR2}) &&
                  bus.HSEL && bus.HREADYIN && bus.HTRANS[1];
  assign amask  = (8'd1 << bus.HSIZE) - 8'd1;
  assign illegal = (64'(bus.HADDR) >= LIMIT) ||
                   (32'(bus.HSIZE) > 32'(LSB)) ||
                   (|(8'(bus.HADDR) & amask));
  assign bm = bytemask(3'(bus.HADDR[LSB-1:0]), bus.HSIZE, NB);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    widx_d  = widx_q;
    be_d    = be_q;
    rd_en   = 1'b0;
    rd_idx  = bus.HADDR[LSB +: IW];
    case (state_q)
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = DATA;
          rd_en   = !write_q;
          rd_idx  = widx_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ERR1: state_d = ERR2;
      default: begin
        if (accept) begin
          write_d = bus.HWRITE;
          widx_d  = bus.HADDR[LSB +: IW];
          be_d    = bm[NB-1:0];
          if (illegal) begin
            state_d = ERR1;
          end else if (WAIT_STATES == 0) begin
            state_d = DATA;
            rd_en   = !bus.HWRITE;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Ready/response are registered straight from the next state.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      write_q  <= write_d;
      hready_q <= !(state_d inside {WAIT, ERR1});
      hresp_q  <= (state_d inside {ERR1, ERR2});
    end
  end

  always_ff @(posedge HCLK) begin
    widx_q <= widx_d;
    be_q   <= be_d;
  end

  assign mem_we = (state_q == DATA) && write_q;

  ahb_slave_mem_array #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (HCLK),
    .rst_n   (HRESETN),
    .we_i    (mem_we),
    .waddr_i (widx_q),
    .be_i    (be_q),
    .wdata_i (bus.HWDATA),
    .re_i    (rd_en),
    .raddr_i (rd_idx),
    .rdata_o (rdata)
  );

  assign bus.HRDATA    = rdata;
  assign bus.HREADYOUT = hready_q;
  assign bus.HRESP     = hresp_q;

endmodule
